// File: rtl/gm64_reset_pkg.sv
// gm64_reset_pkg: shared definitions for the GM64 reset sequencer.
//   - seq_state_e : sequencer FSM states
//   - STG_*       : reset stage indices (bit positions of rst_n_out)
//   - DEF_*       : default parameter values
//   - max_int     : helper used to size the shared delay counter
package gm64_reset_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_DELAY,
    ST_WAIT_MEM,
    ST_RUN,
    ST_SOFT
  } seq_state_e;

  localparam int STG_MEM   = 0;
  localparam int STG_VIDEO = 1;
  localparam int STG_IO    = 2;
  localparam int STG_CPU   = 3;

  localparam int DEF_STAGES      = 4;
  localparam int DEF_STAGE_DELAY = 16;
  localparam int DEF_SOFT_PULSE  = 64;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// reset_sync: asynchronous-assert / synchronous-deassert reset synchronizer.
// Ports:
//   clk        in  clock
//   rst_n_i    in  raw asynchronous active-low reset
//   rst_n_o    out synchronized active-low reset (last flop of the chain)
//   rel_next_o out input of the last flop; high means rst_n_o rises on the
//                  coming clock edge
module reset_sync
  import gm64_reset_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n_i,
  output logic rst_n_o,
  output logic rel_next_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_o    = sync_q[SYNC_STAGES-1];
  assign rel_next_o = sync_q[SYNC_STAGES-2];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged release of the GM64 subsystem resets.
// Stage 0 (memory/clocking) is released first; later stages follow only once
// the memory controller reports ready, each STAGE_DELAY edges apart. A 4-phase
// soft reset (soft_req/soft_ack) re-resets stages 1..STAGES-1 only.
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous active-low board reset
//   mem_ready    in  memory controller init done (synchronous)
//   soft_req     in  soft-reset request level
//   soft_ack     out soft-reset completion acknowledge
//   rst_n_out    out per-stage active-low resets, registered
//   all_released out every stage released
//   busy         out sequencer not in RUN
module reset_sequencer
  import gm64_reset_pkg::*;
#(
  parameter int STAGES      = DEF_STAGES,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int SOFT_PULSE  = DEF_SOFT_PULSE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_ready,
  input  logic              soft_req,
  output logic              soft_ack,
  output logic [STAGES-1:0] rst_n_out,
  output logic              all_released,
  output logic              busy
);

  localparam int CW = $clog2(max_int(STAGE_DELAY, SOFT_PULSE) + 1);
  localparam int IW = $clog2(STAGES);

  logic sync_rst_n;
  logic sync_rel_next;

  seq_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [STAGES-1:0] rst_n_q, rst_n_d;
  logic              ack_q, ack_d;
  // Set while a soft reset is in progress so the return to RUN acknowledges
  // instead of treating a still-high soft_req as a fresh request.
  logic              soft_act_q, soft_act_d;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n_i   (reset),
    .rst_n_o   (sync_rst_n),
    .rel_next_o(sync_rel_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_n_q    <= '0;
      ack_q      <= 1'b0;
      soft_act_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_n_q    <= rst_n_d;
      ack_q      <= ack_d;
      soft_act_q <= soft_act_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_n_d    = rst_n_q;
    ack_d      = ack_q;
    soft_act_d = soft_act_q;

    unique case (state_q)
      ST_HOLD: begin
        // Act on the edge where the synchronizer output itself rises.
        if (sync_rel_next && !sync_rst_n) begin
          cnt_d   = CW'(STAGE_DELAY);
          idx_d   = IW'(STG_MEM);
          state_d = ST_DELAY;
        end
      end

      ST_DELAY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rst_n_d[idx_q] = 1'b1;
          if (idx_q == IW'(STG_MEM)) begin
            state_d = ST_WAIT_MEM;
          end else if (idx_q == IW'(STAGES-1)) begin
            if (soft_act_q) begin
              state_d    = ST_RUN;
              ack_d      = 1'b1;
              soft_act_d = 1'b0;
            end else if (soft_req && !ack_q) begin
              // A request pending from before RUN is honoured on the entry
              // edge itself, overriding the last stage release.
              rst_n_d[STAGES-1:1] = '0;
              cnt_d      = CW'(SOFT_PULSE);
              soft_act_d = 1'b1;
              state_d    = ST_SOFT;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            idx_d = idx_q + IW'(1);
            cnt_d = CW'(STAGE_DELAY);
          end
        end
      end

      ST_WAIT_MEM: begin
        if (mem_ready) begin
          idx_d   = IW'(STG_VIDEO);
          cnt_d   = CW'(STAGE_DELAY);
          state_d = ST_DELAY;
        end
      end

      ST_RUN: begin
        if (ack_q && !soft_req) begin
          ack_d = 1'b0;
        end else if (soft_req && !ack_q) begin
          rst_n_d[STAGES-1:1] = '0;
          cnt_d      = CW'(SOFT_PULSE);
          soft_act_d = 1'b1;
          state_d    = ST_SOFT;
        end
      end

      ST_SOFT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_WAIT_MEM;
        end
      end

      default: state_d = ST_HOLD;
    endcase
  end

  assign rst_n_out    = rst_n_q;
  assign soft_ack     = ack_q;
  assign all_released = &rst_n_q;
  assign busy         = (state_q != ST_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized directed scenarios for reset_sequencer.
// Expected outputs come from release-edge arithmetic: each stage's release
// edge is derived from the sequencing rules, and the outputs at any edge
// follow from comparing the edge number against those release points.
module tb_reset_sequencer;

  localparam int D  = 16;
  localparam int P  = 64;
  localparam int SY = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mem_ready = 1'b0;
  logic       soft_req = 1'b0;
  logic       soft_ack;
  logic       all_released;
  logic       busy;
  logic [3:0] rst_n_out;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Model state for the current scenario (edge numbers relative to edge 1).
  int rel[4];
  int srel[4];
  int S;
  int F;

  reset_sequencer #(
    .STAGES     (4),
    .STAGE_DELAY(D),
    .SOFT_PULSE (P),
    .SYNC_STAGES(SY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_ready   (mem_ready),
    .soft_req    (soft_req),
    .soft_ack    (soft_ack),
    .rst_n_out   (rst_n_out),
    .all_released(all_released),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] exp_rst(input int e);
    logic [3:0] v;
    v[0] = (e >= rel[0]);
    for (int i = 1; i < 4; i++) begin
      v[i] = ((e >= rel[i]) && (e < S)) || (e >= srel[i]);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_all(input string ph);
    logic [3:0] ev;
    logic       ea;
    logic       ack_e;
    ev    = exp_rst(edge_n);
    ea    = &ev;
    ack_e = (edge_n >= srel[3]) && (edge_n < F);
    chk({ph, "/rst_n_out"},    {28'b0, rst_n_out},    {28'b0, ev});
    chk({ph, "/all_released"}, {31'b0, all_released}, {31'b0, ea});
    chk({ph, "/busy"},         {31'b0, busy},         {31'b0, ~ea});
    chk({ph, "/soft_ack"},     {31'b0, soft_ack},     {31'b0, ack_e});
  endtask

  task automatic chk_reset(input string ph);
    chk({ph, "/rst_n_out"},    {28'b0, rst_n_out},    32'h0);
    chk({ph, "/all_released"}, {31'b0, all_released}, 32'h0);
    chk({ph, "/busy"},         {31'b0, busy},         32'h1);
    chk({ph, "/soft_ack"},     {31'b0, soft_ack},     32'h0);
  endtask

  initial begin
    int M, Q, M2, R, abort_at, last;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");

    for (int it = 0; it < 6; it++) begin
      // Scenario parameters: M = first edge mem_ready is high during the
      // initial wait, Q = first edge soft_req is high, M2 = first edge
      // mem_ready is high again after a soft reset starts.
      case (it)
        0: begin M = 1;   Q = 20; end
        1: begin M = 100; Q = 0;  end
        default: begin
          M = $urandom_range(1, 80);
          Q = $urandom_range(1, 140);
        end
      endcase

      rel[0] = SY + D;
      rel[1] = imax(rel[0] + 1, M) + D;
      rel[2] = rel[1] + D;
      rel[3] = rel[2] + D;
      if (it == 1) Q = rel[3] + $urandom_range(1, 30);
      S = imax(Q, rel[3]);
      M2 = (it == 0) ? 0 : S + $urandom_range(0, P + 40);
      srel[0] = rel[0];
      srel[1] = imax(S + P + 1, M2) + D;
      srel[2] = srel[1] + D;
      srel[3] = srel[2] + D;
      R = (it == 0) ? srel[3] + 3 : srel[3] + 1 + $urandom_range(0, 5);
      F = R;

      case (it)
        2:       abort_at = S + 30;
        3:       abort_at = rel[1] + 1 + $urandom_range(0, D - 2);
        default: abort_at = 0;
      endcase
      last = (abort_at != 0) ? abort_at : F + 8;

      // Released just after an edge, so the next rising edge is edge 1.
      reset  = 1'b1;
      edge_n = 0;
      for (int e = 1; e <= last; e++) begin
        if (e < rel[3])       mem_ready = (e >= M);
        else if (e < S)       mem_ready = 1'($urandom_range(0, 1));
        else if (e < srel[3]) mem_ready = (e >= M2);
        else                  mem_ready = 1'($urandom_range(0, 1));
        soft_req = (e >= Q) && (e < R);
        @(posedge clk);
        #1;
        edge_n = e;
        chk_all($sformatf("it%0d", it));
      end

      #2;
      reset     = 1'b0;
      soft_req  = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk_reset($sformatf("it%0d/async", it));
      repeat (3) begin
        @(posedge clk);
        #1;
        chk_reset($sformatf("it%0d/hold", it));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumer end of the system reset line. Takes the board-level active-low `reset` from the reset generator and distributes staged, synchronized active-low resets to the GM64 subsystems: memory/clocking first, then video, I/O and CPU last.
- Gates release of the later stages on memory-controller readiness.
- Offers a 4-phase soft-reset handshake that re-resets all stages except stage 0 without touching memory.

Parameters:
- STAGES, 4, number of reset outputs; must be >= 2; bit 0 = memory/clock domain.
- STAGE_DELAY, 16, clk edges between a release trigger and the release of the next stage; must be >= 2.
- SOFT_PULSE, 64, clk edges stages 1..STAGES-1 are held low on a soft reset; must be >= 2.
- SYNC_STAGES, 2, flops in the reset deassertion synchronizer; must be >= 2.

Ports:
- clk  in  1  system clock; all logic is single-domain.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- mem_ready  in  1  memory controller init done; synchronous to clk.
- soft_req  in  1  soft-reset request, level, 4-phase.
- soft_ack  out  1  soft-reset completion acknowledge.
- rst_n_out  out  STAGES  per-stage reset, active-low, synchronous deassertion.
- all_released  out  1  high when every rst_n_out bit is 1.
- busy  out  1  high whenever the sequencer is not in RUN.

Behaviour:
- Reset assertion: reset=0 asynchronously forces:
  - rst_n_out=0, all_released=0, soft_ack=0, busy=1;
  - synchronizer flops cleared, FSM=HOLD, counter=0.
- Reset applies at any time, including mid-sequence or during a soft reset. Deassertion is synchronized; the sequence then restarts from stage 0.
- Edge numbering: edge 1 is the first rising clk edge with reset=1.
- FSM states: HOLD, DELAY, WAIT_MEM, RUN, SOFT.
- HOLD:
  - Waits for the synchronizer output; it goes high at edge SYNC_STAGES.
  - On that edge: counter loads STAGE_DELAY, go to DELAY; next stage index = 0.
- DELAY:
  - Counter decrements each edge. When it reaches 0, rst_n_out[index] goes to 1.
  - Stage 0 release goes to WAIT_MEM; default timing is edge 18.
  - Other stages: if index == STAGES-1, go to RUN; otherwise index+1, counter reloads STAGE_DELAY, stay in DELAY.
- WAIT_MEM:
  - Samples mem_ready each edge, starting at the edge after entry.
  - The first edge with mem_ready=1 sets index=1, loads counter=STAGE_DELAY and goes to DELAY.
  - While mem_ready=0 it waits indefinitely; no timeout.
- RUN:
  - all_released=1 and busy=0, both asserted on the same edge as the last stage release.
  - mem_ready is ignored in RUN.
- Soft-reset start:
  - Starts in RUN on an edge with soft_req=1 and soft_ack=0.
  - On that edge (edge S): rst_n_out[STAGES-1:1]=0, all_released=0, busy=1, counter=SOFT_PULSE, go to SOFT.
  - rst_n_out[0] stays 1.
- SOFT: counter decrements; at 0 (edge S+SOFT_PULSE) go to WAIT_MEM, then the normal release of stages 1..STAGES-1 follows.
- soft_ack:
  - Rises on the edge the sequence re-enters RUN after a soft reset.
  - Falls on the first edge in RUN with soft_req=0.
  - soft_req held high while soft_ack=1 never retriggers.
  - soft_req rising outside RUN is not lost: it is honoured on the first edge in RUN, provided soft_ack=0 and soft_req is still 1.
  - Only one soft reset per request.
- Stage outputs: every rst_n_out bit is a plain flop output (no glitches), and bits deassert strictly in index order.
- Counter width: $clog2(max(STAGE_DELAY, SOFT_PULSE)+1); no wrap occurs.

Decomposition:
- Package gm64_reset_pkg:
  - FSM state enum (HOLD, DELAY, WAIT_MEM, RUN, SOFT);
  - stage index constants STG_MEM=0, STG_VIDEO=1, STG_IO=2, STG_CPU=3;
  - default parameter constants.
- Sub-module reset_sync: SYNC_STAGES-deep, asynchronous-assert / synchronous-deassert synchronizer. Drives the FSM's internal active-low reset release.

Test Plan:
- Power-up, mem_ready tied 1, defaults, reset released before edge 1 -> rst_n_out[0] rises at edge 18, [1] at 35, [2] at 51, [3] at 67; all_released=1 and busy=0 at edge 67.
- mem_ready held 0 until edge 100 (first sampled high at edge 100) -> rst_n_out stays 4'b0001 through edge 99; [1] at 116, [2] at 132, [3] at 148.
- Soft reset:
  - soft_req=1 sampled at edge S in RUN -> rst_n_out=4'b0001 at S, [1] at S+81, [2] at S+97, [3] at S+113;
  - soft_ack rises at S+113; soft_req held high -> no second soft reset;
  - soft_req=0 -> soft_ack falls on the next edge.
- reset pulled low for 3 clk mid-soft-reset (at S+30) -> outputs 0 immediately (asynchronous), soft_ack=0; full power-up timing restarts relative to the new edge 1.
- reset pulled low between edges during DELAY of stage 2 -> rst_n_out=0 with no clk edge; after release, stage 0 again at edge 18.
- soft_req=1 during initial sequence (edge 20) and kept high -> soft reset starts at edge 67 (first RUN edge); soft_ack rises at edge 180.
